reg_file_mp: RTL

//   Parametrised multi-port register file for the datapath: NUM_RD read ports, two write ports
//   (A = ALU write-back, B = load write-back), optional same-cycle write->read bypass, optional

---
 rtl/reg_file_mp.sv | 78 +++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with two write ports, bypass, load scoreboard and clear sweep.
module reg_file_mp #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     sb_set_en,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] sb, set_m, clr_m;
  logic busy, last, wa_ok, wb_ok, set_ok;
  // An address is live when in range and not the hardwired zero register.
  function automatic logic live(input logic [ADDR_W-1:0] a);
    return (32'(a) < NUM_REGS) && !(ZERO_REG != 0 && a == '0);
  endfunction
  assign busy     = state == SWEEP;
  assign clr_busy = busy;
  assign last     = 32'(idx) == NUM_REGS - 1;
  assign wa_ok    = wa_en & ~busy & live(wa_addr);
  assign wb_ok    = wb_en & ~busy & live(wb_addr);
  assign set_ok   = sb_set_en & ~busy & live(sb_set_addr);
  assign set_m    = NUM_REGS'(set_ok) << sb_set_addr;
  assign clr_m    = NUM_REGS'(wb_ok) << wb_addr;
  always_comb state_nx = busy ? (last ? IDLE : SWEEP) : (clr_req ? SWEEP : IDLE);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= (busy && !last) ? idx + 1'b1 : '0;
    end
  // Port A is written last so it wins a same-address collision with port B.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (busy) begin
      regs[idx] <= '0;
    end else begin
      if (wb_ok) regs[wb_addr] <= wb_data;
      if (wa_ok) regs[wa_addr] <= wa_data;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) sb <= '0;
    else if (clr_req && !busy) sb <= '0;
    else sb <= (sb & ~clr_m) | set_m;
  for (genvar g = 0; g < NUM_RD; g++) begin : gen_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[g*ADDR_W +: ADDR_W];
    assign rd_data[g*DATA_W +: DATA_W] = !live(a) ? '0 :
                                         (BYPASS != 0 && wa_ok && wa_addr == a) ? wa_data :
                                         (BYPASS != 0 && wb_ok && wb_addr == a) ? wb_data : regs[a];
    assign rd_pending[g] = live(a) && sb[a] && !(BYPASS != 0 && wb_en && wb_addr == a);
  end
  assign dbg_data = live(dbg_addr) ? regs[dbg_addr] : '0;
endmodule
